// File: rtl/not_gate_checker.sv
// Observer for a 1-bit inverter: waits for a_in to settle, checks o_in == ~a_in, counts checks/errors.
// Optional CHK_TIMEOUT_EN ends the run with fail=1 after TIMEOUT edge-free cycles in WAIT.
module not_gate_checker #(
    parameter int CNT_W   = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             a_in,
    input  logic             o_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] ALL_ONES    = '1;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          a_q;
    logic          o_q;
    logic          a_prev;
    logic          a_edge;

`ifdef CHK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 1'b0;
            o_q    <= 1'b0;
            a_prev <= 1'b0;
        end else begin
            a_q    <= a_in;
            o_q    <= o_in;
            a_prev <= a_q;
        end
    end

    assign a_edge = a_q ^ a_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            settle_cnt    <= '0;
            chk_cnt       <= '0;
            err_cnt       <= '0;
            fail          <= 1'b0;
            first_err_idx <= ALL_ONES;
`ifdef CHK_TIMEOUT_EN
            idle_cnt      <= '0;
`endif
        end else begin
`ifdef CHK_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            // start outranks stop and any pending compare, in every state
            if (start) begin
                state         <= S_SETTLE;
                settle_cnt    <= SETTLE_LOAD;
                chk_cnt       <= '0;
                err_cnt       <= '0;
                fail          <= 1'b0;
                first_err_idx <= ALL_ONES;
            end else begin
                case (state)
                    S_SETTLE: begin
                        if (stop) begin
                            state <= S_DONE;
                        end else if (a_edge) begin
                            settle_cnt <= SETTLE_LOAD;
                        end else if (settle_cnt == '0) begin
                            state <= S_WAIT;
                            if (chk_cnt != ALL_ONES) chk_cnt <= chk_cnt + CNT_W'(1);
                            // equal input and output means the inverter failed
                            if (o_q == a_q) begin
                                fail <= 1'b1;
                                if (err_cnt != ALL_ONES) err_cnt <= err_cnt + CNT_W'(1);
                                if (err_cnt == '0) first_err_idx <= chk_cnt;
                            end
                        end else begin
                            settle_cnt <= settle_cnt - SW'(1);
                        end
                    end
                    S_WAIT: begin
                        if (stop) begin
                            state <= S_DONE;
                        end else if (a_edge) begin
                            state      <= S_SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
`ifdef CHK_TIMEOUT_EN
                            if (idle_cnt == IW'(TIMEOUT - 1)) begin
                                fail  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                idle_cnt <= idle_cnt + IW'(1);
                            end
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state == S_SETTLE) || (state == S_WAIT);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0) && (chk_cnt != '0);

endmodule
